generation_scheduler: RTL and testbench

- Sequences one Game-of-Life generation across the cell array's NUM_POS tile positions.
- Per position it runs three phases: load array, run one compute step, then write back to memory with an acknowledge handshake.
- Supports free-run at a programmable inter-generation period and single-step on request.
- Sits between the user/PS control interface and the array/memory datapath; replaces the fixed free-running phase counter.

---
 rtl/generation_scheduler_if.sv | 29 ++
 rtl/generation_scheduler.sv | 164 ++++++++++++++++
 tb/tb_generation_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/generation_scheduler_if.sv
// Control/datapath bundle for generation_scheduler: user run/step controls in,
// array/memory phase strobes and status out.
interface generation_scheduler_if #(
  parameter int POS_W = 2,
  parameter int GEN_W = 16
);
  logic             run_en;
  logic             step_req;
  logic [31:0]      period;
  logic             mem_ack;
  logic             write_array;
  logic             run;
  logic             write_mem;
  logic [POS_W-1:0] pos;
  logic             busy;
  logic             gen_done;
  logic [GEN_W-1:0] gen_count;
  logic             ack_err;

  modport master (
    output run_en, step_req, period, mem_ack,
    input  write_array, run, write_mem, pos, busy, gen_done, gen_count, ack_err
  );

  modport slave (
    input  run_en, step_req, period, mem_ack,
    output write_array, run, write_mem, pos, busy, gen_done, gen_count, ack_err
  );
endinterface

// File: rtl/generation_scheduler.sv
// Sequences one Game-of-Life generation (LOAD/RUN/STORE per tile position) in free-run or single-step mode.
// Optional mem_ack timeout with sticky ack_err is enabled by defining GEN_SCHED_ACK_TIMEOUT_EN.
module generation_scheduler #(
  parameter int NUM_POS   = 4,
  parameter int POS_W     = 2,
  parameter int GEN_W     = 16,
  parameter int TO_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  generation_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      period_q, period_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [31:0]      period_eff;
  logic             last_pos;
  logic             store_adv;

  // A zero period would never match timer == period-1, so it is clamped to one cycle.
  assign period_eff = (bus.period == 32'd0) ? 32'd1 : bus.period;
  assign last_pos   = (pos_q == POS_W'(NUM_POS - 1));

`ifdef GEN_SCHED_ACK_TIMEOUT_EN
  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ack_err_q, ack_err_d;
  logic            to_hit;

  // Hits on the TO_CYCLES-th STORE cycle without an ack.
  assign to_hit    = (to_cnt_q == TO_W'(TO_CYCLES - 1));
  assign store_adv = bus.mem_ack || to_hit;
`else
  assign store_adv = bus.mem_ack;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    pos_d       = pos_q;
    gen_count_d = gen_count_q;
`ifdef GEN_SCHED_ACK_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    ack_err_d   = ack_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.step_req) begin
          state_d = S_LOAD;
        end else if (bus.run_en) begin
          state_d  = S_WAIT;
          timer_d  = 32'd0;
          period_d = period_eff;
        end
      end
      S_WAIT: begin
        if (!bus.run_en) begin
          state_d = S_IDLE;
          timer_d = 32'd0;
        end else if (timer_q == period_q - 32'd1) begin
          state_d = S_LOAD;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_STORE;
`ifdef GEN_SCHED_ACK_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_STORE: begin
`ifdef GEN_SCHED_ACK_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (!bus.mem_ack && to_hit) begin
          ack_err_d = 1'b1;
        end
`endif
        if (store_adv) begin
          if (last_pos) begin
            pos_d   = '0;
            state_d = S_DONE;
          end else begin
            pos_d   = pos_q + POS_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        gen_count_d = gen_count_q + GEN_W'(1);
        if (bus.run_en) begin
          state_d  = S_WAIT;
          timer_d  = 32'd0;
          period_d = period_eff;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= 32'd0;
      period_q    <= 32'd1;
      pos_q       <= '0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      pos_q       <= pos_d;
      gen_count_q <= gen_count_d;
    end
  end

`ifdef GEN_SCHED_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      ack_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.ack_err = ack_err_q;
`else
  assign bus.ack_err = 1'b0;
`endif

  assign bus.write_array = (state_q == S_LOAD);
  assign bus.run         = (state_q == S_RUN);
  assign bus.write_mem   = (state_q == S_STORE);
  assign bus.gen_done    = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_RUN) ||
                           (state_q == S_STORE) || (state_q == S_DONE);
  assign bus.pos         = pos_q;
  assign bus.gen_count   = gen_count_q;

endmodule

// File: tb/tb_generation_scheduler.sv
// Scoreboard bench for generation_scheduler: expected strobe events (cycle, kind, pos) are queued
// when stimulus is driven and matched against every strobe/gen_done cycle the DUT produces.
module tb_generation_scheduler;
  localparam int NUM_POS   = 4;
  localparam int POS_W     = 2;
  localparam int GEN_W     = 16;
  localparam int TO_CYCLES = 255;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  generation_scheduler_if #(.POS_W(POS_W), .GEN_W(GEN_W)) bus ();

  generation_scheduler #(
    .NUM_POS  (NUM_POS),
    .POS_W    (POS_W),
    .GEN_W    (GEN_W),
    .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_gen  = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event word: {cycle[15:0], kind, pos}; kind 1=write_array 2=run 3=write_mem 4=gen_done.
  function automatic logic [31:0] ev(input int t, input int k, input int p);
    return {t[15:0], k[7:0], p[7:0]};
  endfunction

  // Queue one full generation whose step/wait-exit cycle is s (LOAD of pos 0 at s+1).
  // stall_pos = -1 applies store_len to every position, otherwise only to stall_pos.
  task automatic push_gen(input int s, input int stall_pos, input int store_len, output int done_cyc);
    int t;
    int n;
    t = s + 1;
    for (int p = 0; p < NUM_POS; p++) begin
      exp_q.push_back(ev(t, 1, p));
      exp_q.push_back(ev(t + 1, 2, p));
      n = (stall_pos == -1 || stall_pos == p) ? store_len : 1;
      for (int k = 0; k < n; k++) exp_q.push_back(ev(t + 2 + k, 3, p));
      t = t + 2 + n;
    end
    exp_q.push_back(ev(t, 4, 0));
    exp_gen++;
    done_cyc = t;
  endtask

  logic [3:0]  hot;
  logic [7:0]  kind;
  logic [31:0] obs;
  logic [31:0] expv;

  always @(negedge clk) begin
    if (mon_en) begin
      hot = {bus.write_array, bus.run, bus.write_mem, bus.gen_done};
      if (hot != 4'd0) begin
        check_eq("excl", $countones(hot), 1);
        kind = bus.write_array ? 8'd1 : bus.run ? 8'd2 : bus.write_mem ? 8'd3 : 8'd4;
        obs  = {cyc[15:0], kind, 8'(bus.pos)};
        if (exp_q.size() == 0) begin
          check_eq("spurious", obs, 32'd0);
        end else begin
          expv = exp_q.pop_front();
          check_eq("event", obs, expv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int c;
    int d;
    bus.run_en   = 1'b0;
    bus.step_req = 1'b0;
    bus.period   = 32'd0;
    bus.mem_ack  = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_pos", bus.pos, 0);
    check_eq("rst_gen_count", bus.gen_count, 0);
    check_eq("rst_ack_err", bus.ack_err, 0);
    check_eq("rst_strobes", {bus.write_array, bus.run, bus.write_mem, bus.gen_done}, 0);
    reset = 1'b0;
    repeat (2) tick();
    check_eq("idle_busy", bus.busy, 0);
    mon_en = 1'b1;

    // Single step, mem_ack tied high: 13-cycle generation.
    s = cyc;
    bus.step_req = 1'b1;
    push_gen(s, -2, 1, d);
    tick();
    bus.step_req = 1'b0;
    drain(100);
    tick();
    check_eq("step_busy", bus.busy, 0);
    check_eq("step_gen_count", bus.gen_count, exp_gen);

    // mem_ack low for 7 cycles at pos 2: write_mem held 8 cycles.
    s = cyc;
    bus.step_req = 1'b1;
    push_gen(s, 2, 8, d);
    tick();
    bus.step_req = 1'b0;
    while (cyc < s + 9) tick();
    bus.mem_ack = 1'b0;
    while (cyc < s + 16) tick();
    bus.mem_ack = 1'b1;
    drain(100);
    check_eq("stall_gen_count", bus.gen_count, exp_gen);

    // Reset in the middle of a generation.
    mon_en = 1'b0;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    repeat (4) tick();
    check_eq("mid_busy", bus.busy, 1);
    check_eq("mid_pos", bus.pos, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_pos", bus.pos, 0);
    check_eq("mid_rst_gen_count", bus.gen_count, 0);
    check_eq("mid_rst_write_mem", bus.write_mem, 0);
    tick();
    exp_gen = 0;
    exp_q.delete();
    mon_en = 1'b1;

    // Free-run, period 10: WAIT(10) + 3*NUM_POS + DONE between gen_done pulses.
    c = cyc;
    bus.period = 32'd10;
    bus.run_en = 1'b1;
    s = c + 10;
    for (int k = 0; k < 5; k++) begin
      push_gen(s, -2, 1, d);
      s = d + 10;
    end
    while (cyc < d + 1) tick();
    bus.run_en = 1'b0;
    drain(50);
    repeat (3) tick();
    check_eq("free_busy", bus.busy, 0);
    check_eq("free_gen_count", bus.gen_count, 5);

    // period=0 behaves as 1; run_en dropped during RUN of pos 1 finishes the generation.
    c = cyc;
    bus.period = 32'd0;
    bus.run_en = 1'b1;
    s = c + 1;
    push_gen(s, -2, 1, d);
    while (cyc < s + 5) tick();
    bus.run_en = 1'b0;
    drain(50);
    repeat (4) tick();
    check_eq("drop_busy", bus.busy, 0);
    check_eq("drop_gen_count", bus.gen_count, exp_gen);

    // step_req and run_en together: immediate LOAD; later step_req in STORE and WAIT dropped.
    s = cyc;
    bus.period   = 32'd5;
    bus.run_en   = 1'b1;
    bus.step_req = 1'b1;
    push_gen(s, -2, 1, d);
    tick();
    bus.step_req = 1'b0;
    while (cyc < s + 3) tick();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    while (cyc < d + 1) tick();
    check_eq("both_wait_busy", bus.busy, 0);
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    bus.run_en   = 1'b0;
    drain(50);
    repeat (8) tick();
    check_eq("both_busy", bus.busy, 0);
    check_eq("both_gen_count", bus.gen_count, exp_gen);

`ifdef GEN_SCHED_ACK_TIMEOUT_EN
    // No ack at all: each STORE times out after TO_CYCLES cycles and ack_err latches.
    s = cyc;
    bus.mem_ack  = 1'b0;
    bus.step_req = 1'b1;
    push_gen(s, -1, TO_CYCLES, d);
    tick();
    bus.step_req = 1'b0;
    drain(NUM_POS * (TO_CYCLES + 2) + 20);
    check_eq("to_ack_err", bus.ack_err, 1);
    check_eq("to_gen_count", bus.gen_count, exp_gen);
    bus.mem_ack = 1'b1;
    repeat (3) tick();
    check_eq("to_ack_err_sticky", bus.ack_err, 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_gen = 0;
    check_eq("to_rst_gen_count", bus.gen_count, 0);
`endif

    check_eq("final_ack_err", bus.ack_err, 0);
    check_eq("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
